jtframe_joyser_ctrl: RTL and testbench
======================================

JTFRAME_JOYSER_CTRL -- requirements
Module: jtframe_joyser_ctrl

Interface
REQ-001 SHALL have parameter CLKDIV, default 8: clk cycles per tick, legal range 2..255.
REQ-002 SHALL have parameter GAP, default 16: idle ticks between scans, legal range 0..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL be in this domain.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port joy_data, input, 1: serial data from the external shift-register chain, active-low buttons.
REQ-006 SHALL have port joy_clk, output, 1: shift clock to the chain.
REQ-007 SHALL have port joy_load, output, 1: parallel-load strobe to the chain, active low.
REQ-008 SHALL have port joy1, output, 6: player 1 {fire2,fire1,up,down,left,right}, active low.
REQ-009 SHALL have port joy2, output, 6: player 2, same order, active low.
REQ-010 SHALL have port scan_done, output, 1: one-cycle pulse per completed scan.

Function
REQ-011 SHALL run a prescaler that counts 0..CLKDIV-1 and issues a tick on the cycle it reaches CLKDIV-1; the prescaler SHALL clear on every state entry.
REQ-012 SHALL implement states IDLE, LOAD, SHIFT, LATCH and WAIT; state changes SHALL occur only on ticks, except LATCH.
REQ-013 IDLE: outputs are idle; on the first tick, go to LOAD.
REQ-014 LOAD: joy_load=0 and joy_clk=0 for exactly one tick; on the tick, go to SHIFT with bit index n=0.
REQ-015 SHIFT: each bit takes two ticks.
  - Tick A: sample joy_data into s[n] and drive joy_clk=1.
  - Tick B: drive joy_clk=0; then n=n+1.
  - After tick B of n=15, go to LATCH.
REQ-016 Bit mapping:
  - s0 up, s1 down, s2 left, s3 right, s4 fire1, s5 fire2 go to joy1.
  - s8..s13 go to joy2 in the same order.
  - s6, s7, s14 and s15 SHALL be ignored.
REQ-017 LATCH: lasts exactly one clk cycle; update joy1/joy2 per Configuration; pulse scan_done=1; go to WAIT.
REQ-018 WAIT: lasts GAP ticks; when GAP=0, go straight from LATCH to LOAD.
REQ-019 Scan period SHALL be (1+32+GAP)*CLKDIV+1 clk cycles, measured from scan_done to the next scan_done.
REQ-020 joy_load SHALL be 1 in every state except LOAD; joy_clk SHALL be 0 except between tick A and tick B.
REQ-021 joy1/joy2 SHALL change only on the LATCH cycle; they SHALL never expose a partially shifted word.

Reset
REQ-022 While rst=1:
  - state=IDLE, prescaler=0, n=0, s=16'hFFFF;
  - joy_clk=0, joy_load=1;
  - joy1=6'h3F, joy2=6'h3F (all released), scan_done=0.
REQ-023 Reset asserted mid-scan SHALL abort the scan without updating joy1/joy2; after release, the first scan SHALL start from LOAD.

Configuration
REQ-024 Macro JTFRAME_JOYSER_DEBOUNCE_EN SHALL select the update rule at LATCH.
REQ-025 With JTFRAME_JOYSER_DEBOUNCE_EN defined:
  - the 12 mapped bits SHALL be stored each scan;
  - joy1/joy2 SHALL update only when the current scan equals the previous scan;
  - scan_done SHALL still pulse every scan;
  - the stored previous scan SHALL reset to all ones.
REQ-026 Without the macro, joy1/joy2 SHALL update every LATCH, and no previous-scan storage SHALL exist.

Verification
REQ-027 Reset release, CLKDIV=4, GAP=2, chain all ones -> joy_load low for 4 cycles; 32 joy_clk edges (16 pulses); scan_done period 141 cycles; joy1=joy2=6'h3F.
REQ-028 Chain returns s0=0 (p1 up) and s12=0 (p2 fire1), rest 1 -> after LATCH (non-debounce): joy1=6'h37, joy2=6'h2F; s6/s14 toggled -> no output change.
REQ-029 Debounce build, scan k has s3=0 and scan k+1 has s3=1 -> joy1 holds its prior value; two consecutive scans with s3=0 -> joy1=6'h3E.
REQ-030 rst pulsed during SHIFT at n=7 with non-idle data -> joy1/joy2 stay 6'h3F, joy_clk=0 and joy_load=1 immediately; next scan is complete and correct.
REQ-031 GAP=0, CLKDIV=2 -> LATCH is followed directly by LOAD; scan_done period 67 cycles; no lost or duplicated bits over 100 scans against a behavioural 74HC165 model.

Source files
------------

// File: rtl/jtframe_joyser_ctrl.sv
// Serial joystick scanner for a two-player 74HC165 chain (16 bits, 12 mapped).
// Define JTFRAME_JOYSER_DEBOUNCE_EN to publish a scan only when it matches the previous one.
module jtframe_joyser_ctrl #(
    parameter int CLKDIV = 8,
    parameter int GAP    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic [5:0] joy1,
    output logic [5:0] joy2,
    output logic       scan_done
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, WAIT} state_t;

    localparam int DIV_M1_I = CLKDIV - 1;
    localparam int GAP_M1_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [7:0] DIV_LAST = DIV_M1_I[7:0];
    localparam logic [7:0] GAP_LAST = GAP_M1_I[7:0];

    state_t      r_state, w_next;
    logic [7:0]  r_div;
    logic [7:0]  r_gap;
    logic [3:0]  r_n;
    logic        r_ph;      // 0: waiting for tick A, 1: waiting for tick B
    logic [15:0] r_s;
    logic        r_jclk, r_load, r_done;
    logic [5:0]  r_joy1, r_joy2;
    logic        w_tick;
    logic [5:0]  w_cur1, w_cur2;
    logic        w_unused;

    assign w_tick = (r_div == DIV_LAST);

    // Output order is {fire2,fire1,up,down,left,right}; the chain delivers up first.
    assign w_cur1   = {r_s[5],  r_s[4],  r_s[0], r_s[1], r_s[2],  r_s[3]};
    assign w_cur2   = {r_s[13], r_s[12], r_s[8], r_s[9], r_s[10], r_s[11]};
    assign w_unused = &{r_s[15:14], r_s[7:6]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_tick) w_next = LOAD;
            LOAD:    if (w_tick) w_next = SHIFT;
            SHIFT:   if (w_tick && r_ph && r_n == 4'd15) w_next = LATCH;
            LATCH:   w_next = (GAP == 0) ? LOAD : WAIT;
            WAIT:    if (w_tick && r_gap == GAP_LAST) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= 8'd0;
            r_gap   <= 8'd0;
            r_n     <= 4'd0;
            r_ph    <= 1'b0;
            r_s     <= 16'hFFFF;
            r_jclk  <= 1'b0;
            r_load  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_div   <= (w_tick || w_next != r_state) ? 8'd0 : r_div + 8'd1;
            r_gap   <= (r_state == WAIT) ? r_gap + {7'd0, w_tick} : 8'd0;
            // Registered strobes line up exactly with the state they decode.
            r_load  <= (w_next != LOAD);
            r_done  <= (w_next == LATCH);
            if (r_state == SHIFT) begin
                if (w_tick) begin
                    r_jclk <= ~r_ph;
                    r_ph   <= ~r_ph;
                    if (!r_ph) r_s[r_n] <= joy_data;
                    else       r_n      <= r_n + 4'd1;
                end
            end else begin
                r_jclk <= 1'b0;
                r_ph   <= 1'b0;
                r_n    <= 4'd0;
            end
        end
    end

`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    logic [11:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 12'hFFF;
            r_joy1 <= 6'h3F;
            r_joy2 <= 6'h3F;
        end else if (r_state == LATCH) begin
            r_prev <= {w_cur1, w_cur2};
            if ({w_cur1, w_cur2} == r_prev) begin
                r_joy1 <= w_cur1;
                r_joy2 <= w_cur2;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_joy1 <= 6'h3F;
            r_joy2 <= 6'h3F;
        end else if (r_state == LATCH) begin
            r_joy1 <= w_cur1;
            r_joy2 <= w_cur2;
        end
    end
`endif

    assign joy_clk   = r_jclk;
    assign joy_load  = r_load;
    assign joy1      = r_joy1;
    assign joy2      = r_joy2;
    assign scan_done = r_done;
endmodule

// File: tb/tb_jtframe_joyser_ctrl.sv
// Directed bench: two scanners (CLKDIV=4/GAP=2 and CLKDIV=2/GAP=0) each driving a 74HC165 pair model.
module tb_jtframe_joyser_ctrl;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b0, rst1 = 1'b0;
    logic jd0, jd1, jc0, jc1, jl0, jl1, dn0, dn1;
    logic [5:0] a1, a2, b1, b2;
    logic [15:0] pat0 = 16'hFFFF, pat1 = 16'hFFFF;
    logic [15:0] ch0 = 16'hFFFF, ch1 = 16'hFFFF;
    logic pc0 = 1'b0, pc1 = 1'b0;
    int ld0 = 0, ed0 = 0, cy0 = 0, ldl0 = 0, edl0 = 0, per0 = 0;
    int ld1 = 0, ed1 = 0, cy1 = 0, ldl1 = 0, edl1 = 0, per1 = 0;
    int nchk = 0, nfail = 0;

    jtframe_joyser_ctrl #(.CLKDIV(4), .GAP(2)) u0 (
        .clk(clk), .rst(rst0), .joy_data(jd0), .joy_clk(jc0), .joy_load(jl0),
        .joy1(a1), .joy2(a2), .scan_done(dn0));
    jtframe_joyser_ctrl #(.CLKDIV(2), .GAP(0)) u1 (
        .clk(clk), .rst(rst1), .joy_data(jd1), .joy_clk(jc1), .joy_load(jl1),
        .joy1(b1), .joy2(b2), .scan_done(dn1));

    // 74HC165 pair: parallel load while low, shift on rising joy_clk, s0 first out.
    assign jd0 = ch0[0];
    assign jd1 = ch1[0];
    always @(posedge clk) begin
        pc0 <= jc0;
        if (!jl0) ch0 <= pat0;
        else if (jc0 && !pc0) ch0 <= {1'b1, ch0[15:1]};
        pc1 <= jc1;
        if (!jl1) ch1 <= pat1;
        else if (jc1 && !pc1) ch1 <= {1'b1, ch1[15:1]};
    end

    // Per-scan stats latched on each scan_done: load-low cycles, joy_clk edges, period.
    always @(posedge clk) begin
        if (dn0) begin
            ldl0 <= ld0; edl0 <= ed0 + int'(jc0 != pc0); per0 <= cy0 + 1;
            ld0 <= 0; ed0 <= 0; cy0 <= 0;
        end else begin
            ld0 <= ld0 + int'(!jl0); ed0 <= ed0 + int'(jc0 != pc0); cy0 <= cy0 + 1;
        end
        if (dn1) begin
            ldl1 <= ld1; edl1 <= ed1 + int'(jc1 != pc1); per1 <= cy1 + 1;
            ld1 <= 0; ed1 <= 0; cy1 <= 0;
        end else begin
            ld1 <= ld1 + int'(!jl1); ed1 <= ed1 + int'(jc1 != pc1); cy1 <= cy1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done0();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dn0) return;
        end
        chk("timeout_u0", 32'd0, 32'd1);
    endtask

    task automatic wait_done1();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dn1) return;
        end
        chk("timeout_u1", 32'd0, 32'd1);
    endtask

    function automatic logic [11:0] map12(input logic [15:0] p);
        return {p[5], p[4], p[0], p[1], p[2], p[3], p[13], p[12], p[8], p[9], p[10], p[11]};
    endfunction

    initial begin
        logic [15:0] p;
        logic [11:0] cur, mprev, ej;
        logic prv;
        int rises;

        #1 rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_joy1", 32'(a1), 32'h3F);
        chk("rst_joy2", 32'(a2), 32'h3F);
        chk("rst_joy_clk", 32'(jc0), 32'd0);
        chk("rst_joy_load", 32'(jl0), 32'd1);
        chk("rst_scan_done", 32'(dn0), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;

        // First scan, chain all ones
        wait_done0();
        @(negedge clk);
        chk("load_low_cycles", 32'(ldl0), 32'd4);
        chk("joy_clk_edges", 32'(edl0), 32'd32);
        chk("idle_joy1", 32'(a1), 32'h3F);
        chk("idle_joy2", 32'(a2), 32'h3F);

        // p1 up + p2 fire1
        pat0 = 16'hEFFE;
        wait_done0(); wait_done0();
        @(negedge clk);
        chk("period_141", 32'(per0), 32'd141);
        chk("p1_up_joy1", 32'(a1), 32'h37);
        chk("p2_fire1_joy2", 32'(a2), 32'h2F);

        // unmapped bits s6/s14 toggled
        pat0 = 16'hAFBE;
        wait_done0(); wait_done0();
        @(negedge clk);
        chk("ignored_joy1", 32'(a1), 32'h37);
        chk("ignored_joy2", 32'(a2), 32'h2F);

        // Debounce sequence on p1 right
        pat0 = 16'hFFFF;
        wait_done0(); wait_done0();
        @(negedge clk);
        chk("release_joy1", 32'(a1), 32'h3F);
        pat0 = 16'hFFF7;
        wait_done0();
        pat0 = 16'hFFFF;
        @(negedge clk);
        chk("right_single_scan", 32'(a1), DEB ? 32'h3F : 32'h3E);
        wait_done0();
        pat0 = 16'hFFF7;
        @(negedge clk);
        chk("right_released", 32'(a1), 32'h3F);
        wait_done0();
        @(negedge clk);
        chk("right_first_of_two", 32'(a1), DEB ? 32'h3F : 32'h3E);
        wait_done0();
        @(negedge clk);
        chk("right_second_of_two", 32'(a1), 32'h3E);

        // Reset during SHIFT at n=7 with all buttons pressed
        pat0 = 16'hFFFF;
        wait_done0(); wait_done0();
        @(negedge clk);
        pat0 = 16'h0000;
        rises = 0;
        prv = jc0;
        for (int i = 0; i < 1000 && rises < 8; i++) begin
            @(negedge clk);
            if (jc0 && !prv) rises++;
            prv = jc0;
        end
        chk("reached_bit7", 32'(rises), 32'd8);
        rst0 = 1'b1;
        #1;
        chk("midrst_joy_clk", 32'(jc0), 32'd0);
        chk("midrst_joy_load", 32'(jl0), 32'd1);
        chk("midrst_joy1", 32'(a1), 32'h3F);
        chk("midrst_joy2", 32'(a2), 32'h3F);
        repeat (3) @(negedge clk);
        chk("midrst_scan_done", 32'(dn0), 32'd0);
        pat0 = 16'hEFFE;
        rst0 = 1'b0;
        wait_done0();
        @(negedge clk);
        chk("post_rst_joy1_first", 32'(a1), DEB ? 32'h3F : 32'h37);
        wait_done0();
        @(negedge clk);
        chk("post_rst_joy1", 32'(a1), 32'h37);
        chk("post_rst_joy2", 32'(a2), 32'h2F);

        // GAP=0, CLKDIV=2 over 100 scans; each pattern held for two scans
        mprev = 12'hFFF;
        ej = 12'hFFF;
        p = 16'hFFFF;
        wait_done1();
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) p = 16'($urandom);
            pat1 = p;
            wait_done1();
            cur = map12(p);
            if (DEB) begin
                if (cur == mprev) ej = cur;
                mprev = cur;
            end else begin
                ej = cur;
            end
            @(negedge clk);
            chk("g0_joy1", 32'(b1), 32'(ej[11:6]));
            chk("g0_joy2", 32'(b2), 32'(ej[5:0]));
            chk("g0_period_67", 32'(per1), 32'd67);
            chk("g0_load_low", 32'(ldl1), 32'd2);
            chk("g0_edges", 32'(edl1), 32'd32);
        end

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule
